// File: rtl/record_playback_reader.sv
// Loop-recorder playback reader: replays stored note events from the event RAM onto a
// valid/ready stream, spacing them by each entry's stored delta.
module record_playback_reader #(
  parameter int RECORD_LENGTH = 8,
  parameter int NOTE_WIDTH    = 7,
  parameter int TICK_WIDTH    = 27,
  parameter int ADDR_WIDTH    = $clog2(RECORD_LENGTH)
) (
  input  logic                                clock,
  input  logic                                reset_l,
  input  logic                                play,
  input  logic                                loop,
  input  logic [ADDR_WIDTH:0]                 rec_count,
  output logic [ADDR_WIDTH-1:0]               rd_addr,
  input  logic [TICK_WIDTH+2*NOTE_WIDTH:0]    rd_data,
  output logic                                ev_valid,
  input  logic                                ev_ready,
  output logic                                ev_on,
  output logic [NOTE_WIDTH-1:0]               ev_note,
  output logic [NOTE_WIDTH-1:0]               ev_velocity,
  output logic                                playing,
  output logic                                done,
  output logic                                all_off
);

  localparam logic [ADDR_WIDTH:0] REC_LEN_W = (ADDR_WIDTH+1)'(RECORD_LENGTH);

  // IDLE wait for play edge | FETCH drive addr | READ latch entry | WAIT count delta | EMIT handshake
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_READ, S_WAIT, S_EMIT} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   index_q, index_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [TICK_WIDTH-1:0]   timer_q, timer_d;
  logic                    on_q, on_d;
  logic [NOTE_WIDTH-1:0]   note_q, note_d;
  logic [NOTE_WIDTH-1:0]   vel_q, vel_d;
  logic                    play_q, play_d;
  logic                    done_q, done_d;
  logic                    all_off_q, all_off_d;
  logic [ADDR_WIDTH:0]     clamp_count;
  logic                    is_last;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    count_d     = count_q;
    timer_d     = timer_q;
    on_d        = on_q;
    note_d      = note_q;
    vel_d       = vel_q;
    play_d      = play;
    done_d      = 1'b0;
    all_off_d   = 1'b0;
    clamp_count = (rec_count > REC_LEN_W) ? REC_LEN_W : rec_count;
    is_last     = ({1'b0, index_q} == (count_q - (ADDR_WIDTH+1)'(1)));

    unique case (state_q)
      S_IDLE: begin
        if (play && !play_q && (clamp_count != '0)) begin
          count_d = clamp_count;
          index_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_READ;
      S_READ: begin
        {timer_d, on_d, note_d, vel_d} = rd_data;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q == '0) state_d = S_EMIT;
        else               timer_d = timer_q - TICK_WIDTH'(1);
      end
      S_EMIT: begin
        if (ev_ready) begin
          if (!is_last) begin
            index_d = index_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end else if (loop) begin
            index_d = '0;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stop wins over everything, including a coincident final transfer.
    if ((state_q != S_IDLE) && !play) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      all_off_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_l) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      on_q      <= 1'b0;
      note_q    <= '0;
      vel_q     <= '0;
      play_q    <= 1'b0;
      done_q    <= 1'b0;
      all_off_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      on_q      <= on_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
      play_q    <= play_d;
      done_q    <= done_d;
      all_off_q <= all_off_d;
    end
  end

  assign rd_addr     = index_q;
  assign ev_valid    = (state_q == S_EMIT);
  assign ev_on       = ev_valid & on_q;
  assign ev_note     = ev_valid ? note_q : '0;
  assign ev_velocity = ev_valid ? vel_q : '0;
  assign playing     = (state_q != S_IDLE);
  assign done        = done_q;
  assign all_off     = all_off_q;

endmodule

// File: tb/tb_record_playback_reader.sv
// Directed bench for record_playback_reader: timing, backpressure, looping, stop and clamping.
module tb_record_playback_reader;
  localparam int RL = 8;
  localparam int NW = 7;
  localparam int TW = 27;
  localparam int AW = 3;
  localparam int DW = TW + 1 + 2*NW;

  logic          clock = 1'b0;
  logic          reset_l = 1'b0;
  logic          play = 1'b0;
  logic          loop = 1'b0;
  logic [AW:0]   rec_count = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          ev_valid;
  logic          ev_ready = 1'b0;
  logic          ev_on;
  logic [NW-1:0] ev_note;
  logic [NW-1:0] ev_velocity;
  logic          playing;
  logic          done;
  logic          all_off;

  logic [DW-1:0] mem [RL];
  logic [2*NW:0] got_q [$];
  int n_chk = 0, n_err = 0, cyc = 0;
  int n_done = 0, n_alloff = 0, n_both = 0, n_valid = 0;

  record_playback_reader #(.RECORD_LENGTH(RL), .NOTE_WIDTH(NW), .TICK_WIDTH(TW)) dut (
    .clock(clock), .reset_l(reset_l), .play(play), .loop(loop), .rec_count(rec_count),
    .rd_addr(rd_addr), .rd_data(rd_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_velocity(ev_velocity), .playing(playing),
    .done(done), .all_off(all_off)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rd_data <= mem[rd_addr];

  always @(negedge clock) begin
    if (reset_l) begin
      if (ev_valid && ev_ready) got_q.push_back({ev_on, ev_note, ev_velocity});
      if (ev_valid) n_valid++;
      if (done) n_done++;
      if (all_off) n_alloff++;
      if (done && all_off) n_both++;
    end
  end

  function automatic logic [DW-1:0] ent(input logic [TW-1:0] d, input logic on,
                                        input logic [NW-1:0] note, input logic [NW-1:0] vel);
    return {d, on, note, vel};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_valid(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      if (ev_valid) begin
        at = cyc;
        return;
      end
      tick();
    end
    check("wait_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_gap();
    play = 1'b0;
    tick();
    tick();
    got_q.delete();
  endtask

  initial begin
    int t0, at, prev, r, v0, d0, a0;
    for (int k = 0; k < RL; k++) mem[k] = '0;

    // Reset with play held high
    mem[0] = ent(0, 1'b1, 7'd3, 7'd4);
    rec_count = 1; play = 1'b1; ev_ready = 1'b1; reset_l = 1'b0;
    repeat (3) tick();
    check("rst_ctl", {playing, done, all_off, ev_valid}, 0);
    check("rst_fields", {ev_on, ev_note, ev_velocity}, 0);
    check("rst_addr", rd_addr, 0);
    reset_l = 1'b1; r = cyc;
    tick();
    check("start_after_rst", playing, 1);
    wait_valid(20, at);
    check("rst_latency", at, r + 4);
    check("rst_event", {ev_on, ev_note, ev_velocity}, {1'b1, 7'd3, 7'd4});
    tick();
    check("rst_done", {done, playing}, 2'b10);
    idle_gap();

    // Three events, deltas 0/5/2, no backpressure
    mem[0] = ent(0, 1'b1, 7'd60, 7'd100);
    mem[1] = ent(5, 1'b0, 7'd60, 7'd0);
    mem[2] = ent(2, 1'b1, 7'd64, 7'd90);
    rec_count = 3; loop = 1'b0;
    play = 1'b1; t0 = cyc;
    wait_valid(50, at);
    check("seq_ev0_cycle", at, t0 + 4);
    check("seq_ev0", {ev_on, ev_note, ev_velocity}, {1'b1, 7'd60, 7'd100});
    tick();
    wait_valid(50, at);
    check("seq_ev1_cycle", at, t0 + 13);
    check("seq_ev1", {ev_on, ev_note, ev_velocity}, {1'b0, 7'd60, 7'd0});
    tick();
    wait_valid(50, at);
    check("seq_ev2_cycle", at, t0 + 19);
    check("seq_ev2", {ev_on, ev_note, ev_velocity}, {1'b1, 7'd64, 7'd90});
    tick();
    check("seq_done", {done, playing, all_off}, 3'b100);
    tick();
    check("seq_done_pulse", done, 0);
    v0 = n_valid;
    repeat (10) tick();
    check("no_replay", {playing, 32'(n_valid - v0)}, 0);
    check("seq_count", got_q.size(), 3);
    idle_gap();

    // Backpressure for 7 cycles
    mem[0] = ent(3, 1'b1, 7'd10, 7'd20);
    mem[1] = ent(0, 1'b0, 7'd10, 7'd0);
    rec_count = 2; ev_ready = 1'b0;
    play = 1'b1; t0 = cyc;
    wait_valid(50, at);
    check("bp_first_cycle", at, t0 + 7);
    for (int k = 0; k < 7; k++) begin
      check("bp_hold", {ev_valid, ev_on, ev_note, ev_velocity, rd_addr},
            {1'b1, 1'b1, 7'd10, 7'd20, 3'd0});
      tick();
    end
    ev_ready = 1'b1; prev = cyc;
    tick();
    wait_valid(50, at);
    check("bp_second_cycle", at, prev + 4);
    check("bp_second", {ev_on, ev_note, ev_velocity}, {1'b0, 7'd10, 7'd0});
    tick();
    check("bp_done", done, 1);
    check("bp_count", got_q.size(), 2);
    idle_gap();

    // Loop over two slots, clear loop before the fourth transfer
    mem[0] = ent(1, 1'b1, 7'd40, 7'd50);
    mem[1] = ent(2, 1'b0, 7'd41, 7'd0);
    rec_count = 2; loop = 1'b1;
    play = 1'b1; prev = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) loop = 1'b0;
      wait_valid(50, at);
      check("loop_order", {ev_on, ev_note}, (k % 2 == 0) ? {1'b1, 7'd40} : {1'b0, 7'd41});
      if (k == 2) check("loop_wrap_cycle", at, prev + 5);
      prev = at;
      tick();
    end
    check("loop_done", {done, playing}, 2'b10);
    check("loop_count", got_q.size(), 4);
    idle_gap();

    // Exact latency on a longer delta
    mem[0] = ent(1000, 1'b1, 7'd1, 7'd1);
    rec_count = 1;
    play = 1'b1; t0 = cyc;
    wait_valid(1100, at);
    check("d1000_cycle", at, t0 + 1004);
    idle_gap();

    // Stop mid-WAIT
    d0 = n_done; a0 = n_alloff; v0 = n_valid;
    play = 1'b1; t0 = cyc;
    while (cyc < t0 + 200) tick();
    check("stop_pre", {playing, ev_valid}, 2'b10);
    play = 1'b0;
    tick();
    check("stop_idle", {playing, all_off, done}, 3'b010);
    tick();
    check("stop_pulse", all_off, 0);
    check("stop_counts", {32'(n_alloff - a0), 32'(n_done - d0), 32'(n_valid - v0)}, {32'd1, 32'd0, 32'd0});
    idle_gap();

    // Stop coincident with the final transfer
    mem[0] = ent(0, 1'b1, 7'd5, 7'd6);
    play = 1'b1;
    wait_valid(20, at);
    play = 1'b0;
    tick();
    check("stop_final", {all_off, done, playing}, 3'b100);
    check("stop_final_consumed", got_q.size(), 1);
    idle_gap();

    // rec_count = 0 does nothing
    rec_count = 0; v0 = n_valid; a0 = n_alloff; d0 = n_done;
    play = 1'b1;
    tick();
    check("zero_idle", playing, 0);
    repeat (5) tick();
    check("zero_quiet", {playing, 32'(n_valid - v0), 32'(n_alloff - a0), 32'(n_done - d0)}, 0);
    idle_gap();

    // rec_count = 12 clamps to 8; a later rec_count change is ignored
    for (int k = 0; k < RL; k++) mem[k] = ent(0, 1'b1, 7'(k + 20), 7'd9);
    rec_count = 12;
    play = 1'b1;
    for (int k = 0; k < RL; k++) begin
      wait_valid(50, at);
      if (k == 0) rec_count = 2;
      check("clamp_note", ev_note, k + 20);
      tick();
    end
    check("clamp_done", done, 1);
    repeat (10) tick();
    check("clamp_count", got_q.size(), RL);
    idle_gap();

    // Full-width delta: a truncated timer would emit within a few cycles
    mem[0] = ent(27'h4000005, 1'b1, 7'd2, 7'd2);
    rec_count = 1; v0 = n_valid;
    play = 1'b1;
    repeat (300) tick();
    check("wide_delta_wait", {playing, 32'(n_valid - v0)}, {1'b1, 32'd0});
    idle_gap();

    check("done_alloff_overlap", n_both, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
